dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port data memory between the single-cycle CPU data port and a DMA/debug requester port. The CPU keeps the port when it wants it, except that a DMA request waiting too long is forced through, and the DMA side can lock the port for short bursts. The CPU sees a same-cycle stall, while the DMA side uses a valid/ready handshake with registered read return. The block sits between the CPU core's data-memory connections and the data memory instance.

## Interface
- STARVE_MAX, 4: cycles a pending DMA request may be refused before it is forced through (1..15).
- BURST_MAX, 8: maximum DMA beats per lock (1..15).
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU wants the memory port this cycle.
- cpu_we  in  1  CPU write enable.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU write data.
- cpu_rdata  out  32  memory read data for the CPU, combinational.
- cpu_stall  out  1  CPU access not performed this cycle; the CPU must freeze PC and register writes.
- dma_valid  in  1  DMA beat request.
- dma_ready  out  1  DMA beat accepted this cycle.
- dma_we  in  1  DMA write enable.
- dma_addr  in  32  DMA byte address.
- dma_wdata  in  32  DMA write data.
- dma_lock  in  1  keep DMA ownership after this beat (burst).
- dma_rvalid  out  1  registered read-return strobe.
- dma_rdata  out  32  registered read data.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, combinational in mem_addr.
- owner  out  2  current grant: 00 none, 01 CPU, 10 DMA.

## Operation
- State machine: ARB and LOCK.
- Counters:
  - starve_cnt, 4 bits, saturating at STARVE_MAX.
  - beat_cnt, 4 bits.
- Grant in ARB, combinational:
  - DMA if dma_valid and (cpu_req == 0 or starve_cnt == STARVE_MAX).
  - Otherwise CPU if cpu_req.
  - Otherwise none.
- Grant in LOCK:
  - DMA is always the owner.
  - dma_ready = dma_valid.
  - The CPU is stalled whenever cpu_req is high.
- Ready and stall outputs:
  - dma_ready = dma_valid & DMA granted.
  - cpu_stall = cpu_req & not CPU granted.
- Memory outputs:
  - mem_* are muxed from the granted side.
  - With no grant, or in LOCK with dma_valid low: mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_rdata = mem_rdata at all times.
- starve_cnt:
  - Increments when dma_valid & !dma_ready.
  - Cleared when a DMA beat is accepted, or when dma_valid is low.
- Entering LOCK: ARB goes to LOCK when a DMA beat is accepted with dma_lock=1 and BURST_MAX > 1. beat_cnt is loaded with 1.
- LOCK beats: every accepted beat increments beat_cnt.
- Leaving LOCK: return to ARB at the edge where either condition holds:
  - dma_lock == 0, sampled every cycle, with or without a beat.
  - An accepted beat makes beat_cnt reach BURST_MAX.
- On return to ARB, beat_cnt is cleared.
- The first ARB cycle after LOCK applies normal CPU priority, because starve_cnt is 0.
- Read return: on an accepted DMA read (dma_we=0), dma_rdata <= mem_rdata and dma_rvalid <= 1 at the next edge. Otherwise dma_rvalid <= 0. dma_rdata holds its last value.
- Width rules:
  - Addresses pass through unmodified; alignment is the requester's responsibility.
  - Counters never wrap: starve_cnt saturates, and beat_cnt is bounded by BURST_MAX.

## Timing
- CPU access: zero latency. When granted, write occurs at the current edge and read data is valid in the same cycle.
- DMA write: commits at the edge where dma_valid & dma_ready.
- DMA read: data on dma_rdata with dma_rvalid high exactly one cycle after acceptance.
- Back-to-back DMA reads give continuous dma_rvalid.
- A DMA request waiting under continuous cpu_req is accepted no later than the (STARVE_MAX+1)-th cycle of its wait.
- Reset (async assert, sync-safe deassert by the system):
  - state=ARB, starve_cnt=0, beat_cnt=0, dma_rvalid=0, dma_rdata=0.
  - While reset_n is low, grants are forced to none: dma_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, owner=00, cpu_stall=cpu_req.
- Reset mid-burst: LOCK is abandoned immediately and any pending dma_rvalid is dropped.
- Simultaneous cpu_req and dma_valid with starve_cnt < STARVE_MAX: CPU wins and starve_cnt increments.

## Test plan
- Reset and idle: reset_n=0 with cpu_req=1 and dma_valid=1 -> cpu_stall=1, dma_ready=0, mem_we=0, owner=00. After release with no requests -> all mem_* = 0.
- CPU only: write 0x12345678 to 0x40, then read 0x40 -> mem_we=1 in the write cycle, cpu_rdata=0x12345678 in the read cycle, cpu_stall=0 throughout.
- DMA read latency: DMA read of 0x80 (memory holds 0xCAFEF00D) with no CPU request -> dma_ready=1 in cycle t, dma_rvalid=1 and dma_rdata=0xCAFEF00D in cycle t+1, dma_rvalid=0 in t+2.
- Starvation: cpu_req held high and dma_valid high from cycle 0, STARVE_MAX=4 -> CPU granted cycles 0–3, DMA accepted cycle 4 with cpu_stall=1, CPU granted again cycle 5.
- Burst lock: DMA writes 0x100..0x11C with dma_lock=1 for 10 beats, BURST_MAX=8, cpu_req=1 -> 8 consecutive DMA writes with the CPU stalled, then one CPU cycle. Early lock drop after beat 3 -> CPU granted on the next cycle.
- Reset mid-burst: assert reset_n=0 during LOCK beat 2 with a read outstanding -> dma_rvalid=0 and owner=00 immediately. After release, arbitration restarts in ARB with CPU priority.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data memory between the single-cycle CPU data port
// and a DMA/debug requester. The CPU normally wins. A DMA request that has been
// refused STARVE_MAX times in a row is forced through, and the DMA side may
// lock the port for bursts of up to BURST_MAX beats.
//
// Ports
//   clk, reset_n                 clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata        CPU access request, served in the same cycle
//   cpu_rdata, cpu_stall         CPU read data (combinational), access-refused
//   dma_valid/ready              DMA beat handshake
//   dma_we/addr/wdata/lock       DMA beat payload; lock keeps ownership
//   dma_rvalid, dma_rdata        registered read return, one cycle after accept
//   mem_we/addr/wdata/rdata      memory port (rdata combinational in mem_addr)
//   owner                        current grant: 00 none, 01 CPU, 10 DMA
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int STARVE_MAX = 4,   // 1..15
   parameter int BURST_MAX  = 8    // 1..15
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        dma_valid,
   output logic        dma_ready,
   input  logic        dma_we,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   input  logic        dma_lock,
   output logic        dma_rvalid,
   output logic [31:0] dma_rdata,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  owner
);

   typedef enum logic [0:0] {
      ST_ARB  = 1'b0,
      ST_LOCK = 1'b1
   } state_e;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
   localparam logic [3:0] BURST_LIM  = 4'(BURST_MAX);
   // With a single-beat limit a lock could never span more than one beat,
   // so LOCK is never entered.
   localparam logic       BURST_EN   = (BURST_MAX > 1) ? 1'b1 : 1'b0;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_CPU  = 2'b01;
   localparam logic [1:0] OWN_DMA  = 2'b10;

   // Saturating 4-bit increment; the counter parks at lim instead of wrapping.
   function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
      if (v >= lim) begin
         return lim;
      end else begin
         return v + 4'd1;
      end
   endfunction

   state_e      state_q, state_d;
   logic [3:0]  starve_q, starve_d;
   logic [3:0]  beat_q, beat_d;
   logic        rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;

   logic        cpu_gnt_s;
   logic        dma_gnt_s;
   logic        dma_acc_s;
   logic [3:0]  beat_inc_s;

   // State register, counters and registered read return.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_ARB;
         starve_q <= 4'd0;
         beat_q   <= 4'd0;
         rvalid_q <= 1'b0;
         rdata_q  <= 32'd0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         beat_q   <= beat_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

   // Grant decision and memory-port mux. While reset_n is low nobody is
   // granted, so the memory sees no access and a requesting CPU is stalled.
   always_comb begin
      cpu_gnt_s = 1'b0;
      dma_gnt_s = 1'b0;
      owner     = OWN_NONE;
      if (!reset_n) begin
         cpu_gnt_s = 1'b0;
         dma_gnt_s = 1'b0;
      end else begin
         case (state_q)
            ST_ARB: begin
               if (dma_valid && (!cpu_req || (starve_q == STARVE_LIM))) begin
                  dma_gnt_s = 1'b1;
                  owner     = OWN_DMA;
               end else if (cpu_req) begin
                  cpu_gnt_s = 1'b1;
                  owner     = OWN_CPU;
               end else begin
                  owner     = OWN_NONE;
               end
            end
            ST_LOCK: begin
               // DMA owns the port for the whole lock, beat or no beat.
               dma_gnt_s = 1'b1;
               owner     = OWN_DMA;
            end
            default: begin
               owner     = OWN_NONE;
            end
         endcase
      end

      dma_acc_s = dma_valid & dma_gnt_s;
      dma_ready = dma_acc_s;
      cpu_stall = cpu_req & ~cpu_gnt_s;
      cpu_rdata = mem_rdata;

      if (cpu_gnt_s) begin
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (dma_acc_s) begin
         mem_we    = dma_we;
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
      end else begin
         // Idle port, including LOCK cycles without a beat.
         mem_we    = 1'b0;
         mem_addr  = 32'd0;
         mem_wdata = 32'd0;
      end

      dma_rvalid = rvalid_q;
      dma_rdata  = rdata_q;
   end

   // Next state, starvation/beat counters and read-return capture.
   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      starve_d   = 4'd0;
      beat_inc_s = beat_q + 4'd1;

      // Counts consecutive refused cycles; any accept or idle cycle clears it.
      if (dma_valid && !dma_acc_s) begin
         starve_d = sat_inc(starve_q, STARVE_LIM);
      end else begin
         starve_d = 4'd0;
      end

      case (state_q)
         ST_ARB: begin
            beat_d = 4'd0;
            if (dma_acc_s && dma_lock && BURST_EN) begin
               state_d = ST_LOCK;
               beat_d  = 4'd1;
            end else begin
               state_d = ST_ARB;
            end
         end
         ST_LOCK: begin
            if (dma_acc_s) begin
               beat_d = beat_inc_s;
            end else begin
               beat_d = beat_q;
            end
            // The lock ends when it is released or when the beat just taken
            // was the last one allowed.
            if (!dma_lock || (dma_acc_s && (beat_inc_s == BURST_LIM))) begin
               state_d = ST_ARB;
               beat_d  = 4'd0;
            end else begin
               state_d = ST_LOCK;
            end
         end
         default: begin
            state_d = ST_ARB;
            beat_d  = 4'd0;
         end
      endcase

      rvalid_d = dma_acc_s & ~dma_we;
      if (rvalid_d) begin
         rdata_d = mem_rdata;
      end else begin
         rdata_d = rdata_q;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Self-checking bench for dmem_arbiter (STARVE_MAX=4, BURST_MAX=8). A small
// word memory model sits on the memory port. Expected DMA read-return data is
// pushed into a queue when the read is driven and popped when dma_rvalid is
// due; every other expectation is a constant of the scenario.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_stall;
   logic        dma_valid, dma_ready, dma_we, dma_lock, dma_rvalid;
   logic [31:0] dma_addr, dma_wdata, dma_rdata;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  owner;

   logic [31:0] mem [0:255];
   logic [31:0] exp_q [$];
   logic [31:0] exp_v;
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.STARVE_MAX(4), .BURST_MAX(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_we(dma_we),
      .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_lock(dma_lock),
      .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .owner(owner)
   );

   assign mem_rdata = mem[mem_addr[9:2]];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
      dma_valid = 1'b0; dma_we = 1'b0; dma_addr = 32'd0; dma_wdata = 32'd0;
      dma_lock = 1'b0;
   endtask

   task automatic dma_beat(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic lk);
      dma_valid = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d; dma_lock = lk;
   endtask

   task automatic test_reset();
      idle();
      reset_n = 1'b0; cpu_req = 1'b1;
      dma_beat(1'b1, 32'h44, 32'h1111_2222, 1'b1);
      #2;
      n_vec++;
      if (cpu_stall !== 1'b1 || dma_ready !== 1'b0) begin
         n_err++; $display("FAIL reset_hs: stall=%b ready=%b, want 1/0", cpu_stall, dma_ready);
      end
      n_vec++;
      if (mem_we !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0 || owner !== 2'b00) begin
         n_err++; $display("FAIL reset_mem: we=%b addr=%h wdata=%h owner=%b, want 0/0/0/00",
                           mem_we, mem_addr, mem_wdata, owner);
      end
      n_vec++;
      if (dma_rvalid !== 1'b0 || dma_rdata !== 32'd0) begin
         n_err++; $display("FAIL reset_rd: rvalid=%b rdata=%h, want 0/0", dma_rvalid, dma_rdata);
      end
      step(); step();
      reset_n = 1'b1; idle();
      @(negedge clk);
      n_vec++;
      if (mem_we !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0 || owner !== 2'b00
          || cpu_stall !== 1'b0 || dma_ready !== 1'b0) begin
         n_err++; $display("FAIL idle: we=%b addr=%h wdata=%h owner=%b stall=%b ready=%b, want all 0",
                           mem_we, mem_addr, mem_wdata, owner, cpu_stall, dma_ready);
      end
   endtask

   task automatic test_cpu_only();
      step(); idle();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h1234_5678;
      @(negedge clk);
      n_vec++;
      if (mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'h1234_5678
          || cpu_stall !== 1'b0 || owner !== 2'b01) begin
         n_err++; $display("FAIL cpu_wr: we=%b addr=%h wdata=%h stall=%b owner=%b, want 1/40/12345678/0/01",
                           mem_we, mem_addr, mem_wdata, cpu_stall, owner);
      end
      step(); cpu_we = 1'b0;
      @(negedge clk);
      n_vec++;
      if (cpu_rdata !== 32'h1234_5678 || mem_we !== 1'b0 || cpu_stall !== 1'b0) begin
         n_err++; $display("FAIL cpu_rd: rdata=%h we=%b stall=%b, want 12345678/0/0",
                           cpu_rdata, mem_we, cpu_stall);
      end
      step(); cpu_we = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'hCAFE_F00D;
      @(negedge clk);
      n_vec++;
      if (mem_we !== 1'b1 || mem_addr !== 32'h80 || cpu_stall !== 1'b0) begin
         n_err++; $display("FAIL cpu_wr2: we=%b addr=%h stall=%b, want 1/80/0", mem_we, mem_addr, cpu_stall);
      end
      step(); idle();
   endtask

   task automatic test_dma_read();
      step(); idle();
      dma_beat(1'b0, 32'h80, 32'd0, 1'b0);
      exp_q.push_back(32'hCAFE_F00D);
      @(negedge clk);
      n_vec++;
      if (dma_ready !== 1'b1 || owner !== 2'b10 || mem_addr !== 32'h80 || mem_we !== 1'b0) begin
         n_err++; $display("FAIL dma_acc: ready=%b owner=%b addr=%h we=%b, want 1/10/80/0",
                           dma_ready, owner, mem_addr, mem_we);
      end
      step(); idle();
      @(negedge clk);
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      n_vec++;
      if (dma_rvalid !== 1'b1 || dma_rdata !== exp_v) begin
         n_err++; $display("FAIL dma_ret: rvalid=%b rdata=%h, want 1/%h", dma_rvalid, dma_rdata, exp_v);
      end
      step();
      @(negedge clk);
      n_vec++;
      if (dma_rvalid !== 1'b0 || dma_rdata !== 32'hCAFE_F00D) begin
         n_err++; $display("FAIL dma_ret_end: rvalid=%b rdata=%h, want 0/cafef00d", dma_rvalid, dma_rdata);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] addrs [3];
      logic [31:0] datas [3];
      addrs = '{32'h40, 32'h80, 32'h40};
      datas = '{32'h1234_5678, 32'hCAFE_F00D, 32'h1234_5678};
      step(); idle();
      for (int c = 0; c < 5; c++) begin
         if (c < 3) begin
            dma_beat(1'b0, addrs[c], 32'd0, 1'b0);
            exp_q.push_back(datas[c]);
         end else begin
            idle();
         end
         @(negedge clk);
         if (c >= 1 && c <= 3) begin
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            n_vec++;
            if (dma_rvalid !== 1'b1 || dma_rdata !== exp_v) begin
               n_err++; $display("FAIL b2b_ret%0d: rvalid=%b rdata=%h, want 1/%h",
                                 c, dma_rvalid, dma_rdata, exp_v);
            end
         end else if (c == 4) begin
            n_vec++;
            if (dma_rvalid !== 1'b0) begin
               n_err++; $display("FAIL b2b_end: rvalid=%b, want 0", dma_rvalid);
            end
         end
         step();
      end
   endtask

   task automatic test_starvation();
      idle();
      cpu_req = 1'b1; cpu_addr = 32'h40;
      dma_beat(1'b1, 32'h88, 32'hA5A5_0001, 1'b0);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_vec++;
         if (c == 4) begin
            if (owner !== 2'b10 || dma_ready !== 1'b1 || cpu_stall !== 1'b1 || mem_addr !== 32'h88) begin
               n_err++; $display("FAIL starve_c%0d: owner=%b ready=%b stall=%b addr=%h, want 10/1/1/88",
                                 c, owner, dma_ready, cpu_stall, mem_addr);
            end
         end else begin
            if (owner !== 2'b01 || dma_ready !== 1'b0 || cpu_stall !== 1'b0) begin
               n_err++; $display("FAIL starve_c%0d: owner=%b ready=%b stall=%b, want 01/0/0",
                                 c, owner, dma_ready, cpu_stall);
            end
         end
         step();
      end
      idle(); cpu_req = 1'b1; cpu_addr = 32'h88;
      @(negedge clk);
      n_vec++;
      if (cpu_rdata !== 32'hA5A5_0001) begin
         n_err++; $display("FAIL starve_wr: rdata=%h, want a5a50001", cpu_rdata);
      end
      step(); idle();
   endtask

   task automatic test_burst();
      int k;
      k = 0;
      step(); idle();
      for (int c = 0; c < 9; c++) begin
         cpu_req = (c > 0); cpu_we = 1'b0; cpu_addr = 32'h40;
         dma_beat(1'b1, 32'h100 + 32'(4 * k), 32'hB000_0000 + 32'(k), 1'b1);
         @(negedge clk);
         n_vec++;
         if (c < 8) begin
            if (dma_ready !== 1'b1 || owner !== 2'b10 || cpu_stall !== (c > 0)
                || mem_we !== 1'b1 || mem_addr !== 32'h100 + 32'(4 * c)) begin
               n_err++; $display("FAIL burst_b%0d: ready=%b owner=%b stall=%b we=%b addr=%h, want 1/10/%0d/1/%h",
                                 c, dma_ready, owner, cpu_stall, mem_we, mem_addr, (c > 0), 32'h100 + 32'(4 * c));
            end
         end else begin
            if (dma_ready !== 1'b0 || owner !== 2'b01 || cpu_stall !== 1'b0) begin
               n_err++; $display("FAIL burst_end: ready=%b owner=%b stall=%b, want 0/01/0",
                                 dma_ready, owner, cpu_stall);
            end
         end
         if (dma_ready === 1'b1) k++;
         step();
      end
      idle(); cpu_req = 1'b1; cpu_addr = 32'h11C;
      @(negedge clk);
      n_vec++;
      if (cpu_rdata !== 32'hB000_0007) begin
         n_err++; $display("FAIL burst_data: rdata=%h, want b0000007", cpu_rdata);
      end
      step(); idle();
   endtask

   task automatic test_early_drop();
      step(); idle();
      for (int c = 0; c < 5; c++) begin
         cpu_req = (c > 0); cpu_addr = 32'h40;
         if (c < 3) dma_beat(1'b1, 32'h180 + 32'(4 * c), 32'hD0 + 32'(c), 1'b1);
         else begin dma_valid = 1'b0; dma_lock = 1'b0; end
         @(negedge clk);
         n_vec++;
         if (c < 3) begin
            if (dma_ready !== 1'b1 || owner !== 2'b10) begin
               n_err++; $display("FAIL drop_b%0d: ready=%b owner=%b, want 1/10", c, dma_ready, owner);
            end
         end else if (c == 3) begin
            if (owner !== 2'b10 || cpu_stall !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'd0) begin
               n_err++; $display("FAIL drop_gap: owner=%b stall=%b we=%b addr=%h, want 10/1/0/0",
                                 owner, cpu_stall, mem_we, mem_addr);
            end
         end else begin
            if (owner !== 2'b01 || cpu_stall !== 1'b0) begin
               n_err++; $display("FAIL drop_cpu: owner=%b stall=%b, want 01/0", owner, cpu_stall);
            end
         end
         step();
      end
      idle();
   endtask

   task automatic test_reset_mid_burst();
      step(); idle();
      dma_beat(1'b0, 32'h40, 32'd0, 1'b1);
      exp_q.push_back(32'h1234_5678);
      @(negedge clk);
      step();
      cpu_req = 1'b1;
      dma_beat(1'b0, 32'h80, 32'd0, 1'b1);
      @(negedge clk);
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      n_vec++;
      if (dma_rvalid !== 1'b1 || dma_rdata !== exp_v || dma_ready !== 1'b1 || cpu_stall !== 1'b1) begin
         n_err++; $display("FAIL rmb_beat2: rvalid=%b rdata=%h ready=%b stall=%b, want 1/%h/1/1",
                           dma_rvalid, dma_rdata, dma_ready, cpu_stall, exp_v);
      end
      exp_q.push_back(32'hCAFE_F00D);
      step();
      reset_n = 1'b0;
      #1;
      // The outstanding return is abandoned by the reset.
      exp_q.delete();
      n_vec++;
      if (dma_rvalid !== 1'b0 || owner !== 2'b00 || dma_ready !== 1'b0 || cpu_stall !== 1'b1
          || dma_rdata !== 32'd0) begin
         n_err++; $display("FAIL rmb_reset: rvalid=%b owner=%b ready=%b stall=%b rdata=%h, want 0/00/0/1/0",
                           dma_rvalid, owner, dma_ready, cpu_stall, dma_rdata);
      end
      step(); step();
      reset_n = 1'b1;
      @(negedge clk);
      n_vec++;
      if (owner !== 2'b01 || cpu_stall !== 1'b0 || dma_ready !== 1'b0) begin
         n_err++; $display("FAIL rmb_restart: owner=%b stall=%b ready=%b, want 01/0/0",
                           owner, cpu_stall, dma_ready);
      end
      step(); idle();
      @(negedge clk);
      n_vec++;
      if (dma_rvalid !== 1'b0 || owner !== 2'b00) begin
         n_err++; $display("FAIL rmb_idle: rvalid=%b owner=%b, want 0/00", dma_rvalid, owner);
      end
   endtask

   initial begin
      test_reset();
      test_cpu_only();
      test_dma_read();
      test_back_to_back();
      test_starvation();
      test_burst();
      test_early_drop();
      test_reset_mid_burst();
      if (exp_q.size() != 0) begin
         n_vec++; n_err++;
         $display("FAIL scoreboard_left: %0d entries, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
